// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_t : responder FSM states
//   req_t   : request fields captured at accept time
//   WORD_BYTES, CNT_W : word width in bytes, latency counter width
package dmem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic                    wen;
        logic [31:0]             addr;
        logic [31:0]             wdata;
        logic [WORD_BYTES-1:0]   wmask;
    } req_t;

endpackage

// File: rtl/dmem_resp_if.sv
// Load/store bus between the LSU (master) and the data-memory responder (slave).
//   req_* : request channel, valid/ready handshake, master -> slave
//   rsp_* : response channel, valid/ready handshake, slave -> master
interface dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// Word storage split into four byte lanes.
//   clk   : clock
//   we    : per-lane write enable (bit i writes wdata[8i+7:8i])
//   re    : read enable; rdata updates on the next rising edge
//   idx   : word index
//   wdata : write word
//   rdata : registered read word
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic [WORD_BYTES-1:0] we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];
        logic [7:0] rd_q;

        // NOTE: storage and its read register have no reset so they map onto
        // RAM macros; consumers must qualify rd_q with their own valid flag.
        always_ff @(posedge clk) begin
            if (we[i]) lane_mem[idx] <= wdata[8*i +: 8];
            if (re)    rd_q          <= lane_mem[idx];
        end

        assign rdata[8*i +: 8] = rd_q;
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, performs a byte-masked write or full-word read, then holds the
// response until the initiator takes it.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : slave side of the load/store bus (request + response channels)
module dmem_resp
    import dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1
) (
    input  logic         clk,
    input  logic         rst,
    dmem_resp_if.slave   bus
);

    localparam int               IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(LATENCY);
    localparam bit               LAT_ZERO = (LATENCY == 0);

    state_t           state;
    req_t             req_q;
    logic [CNT_W-1:0] cnt;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic             rd_hit_q;

    req_t              acc_req;
    logic [31:0]       offset;
    logic              in_range;
    logic              commit;
    logic [IDX_W-1:0]  bank_idx;
    logic [3:0]        bank_we;
    logic              bank_re;
    logic [31:0]       bank_rdata;

    // The access fires on the edge that enters RESP. With zero latency that
    // is the accept edge itself, so the live request is used instead of the
    // (not yet loaded) latched copy.
    // NOTE: every signal written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        acc_req   = req_q;
        commit    = 1'b0;
        if (state == IDLE) begin
            acc_req.wen   = bus.req_wen;
            acc_req.addr  = bus.req_addr;
            acc_req.wdata = bus.req_wdata;
            acc_req.wmask = bus.req_wmask;
            commit        = LAT_ZERO && bus.req_valid;
        end else if (state == WAIT) begin
            commit = (cnt == CNT_W'(1));
        end

        // Unsigned compare on the raw address: anything below the base fails
        // the first term, so the wrapped subtraction never yields a hit.
        offset   = acc_req.addr - ADDR_BASE;
        in_range = (acc_req.addr >= ADDR_BASE) &&
                   ((offset >> 2) < 32'(DEPTH_WORDS));
        bank_idx = offset[IDX_W+1:2];
        bank_we  = (commit && in_range && acc_req.wen) ? acc_req.wmask : 4'b0000;
        bank_re  = commit && in_range && !acc_req.wen;
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .re    (bank_re),
        .idx   (bank_idx),
        .wdata (acc_req.wdata),
        .rdata (bank_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= '0;
            cnt         <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_hit_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q       <= acc_req;
                        cnt         <= LAT_CNT;
                        req_ready_q <= 1'b0;
                        if (LAT_ZERO) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= !in_range;
                            rd_hit_q    <= in_range && !acc_req.wen;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !in_range;
                        rd_hit_q    <= in_range && !acc_req.wen;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rd_hit_q    <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rd_hit_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    // Bank read register is unreset and only meaningful for in-range reads.
    assign bus.rsp_rdata = rd_hit_q ? bank_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Common stimulus, steered to one of three DUTs by sel.
    int          sel = 0;
    logic        req_valid = 1'b0;
    logic        req_wen   = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        rsp_ready = 1'b1;

    logic        req_ready_m, rsp_valid_m, rsp_err_m;
    logic [31:0] rsp_rdata_m;

    dmem_resp_if if0 ();
    dmem_resp_if if1 ();
    dmem_resp_if if2 ();

    assign if0.req_valid = req_valid && (sel == 0);
    assign if1.req_valid = req_valid && (sel == 1);
    assign if2.req_valid = req_valid && (sel == 2);
    assign if0.rsp_ready = rsp_ready && (sel == 0);
    assign if1.rsp_ready = rsp_ready && (sel == 1);
    assign if2.rsp_ready = rsp_ready && (sel == 2);
    assign {if0.req_wen, if0.req_addr, if0.req_wdata, if0.req_wmask} = {req_wen, req_addr, req_wdata, req_wmask};
    assign {if1.req_wen, if1.req_addr, if1.req_wdata, if1.req_wmask} = {req_wen, req_addr, req_wdata, req_wmask};
    assign {if2.req_wen, if2.req_addr, if2.req_wdata, if2.req_wmask} = {req_wen, req_addr, req_wdata, req_wmask};

    always_comb begin
        req_ready_m = if0.req_ready;
        rsp_valid_m = if0.rsp_valid;
        rsp_rdata_m = if0.rsp_rdata;
        rsp_err_m   = if0.rsp_err;
        if (sel == 1) begin
            req_ready_m = if1.req_ready;
            rsp_valid_m = if1.rsp_valid;
            rsp_rdata_m = if1.rsp_rdata;
            rsp_err_m   = if1.rsp_err;
        end else if (sel == 2) begin
            req_ready_m = if2.req_ready;
            rsp_valid_m = if2.rsp_valid;
            rsp_rdata_m = if2.rsp_rdata;
            rsp_err_m   = if2.rsp_err;
        end
    end

    dmem_resp #(.ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(4096), .LATENCY(1))
        u_dut_l1  (.clk(clk), .rst(rst), .bus(if0.slave));
    dmem_resp #(.ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(16), .LATENCY(0))
        u_dut_l0  (.clk(clk), .rst(rst), .bus(if1.slave));
    dmem_resp #(.ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(16), .LATENCY(15))
        u_dut_l15 (.clk(clk), .rst(rst), .bus(if2.slave));

    int lat_of [3] = '{1, 0, 15};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: {err, rdata} pushed at issue, popped by the monitor.
    logic [32:0] exp_q [$];

    always @(negedge clk) begin
        if (rsp_valid_m && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid_m), 32'h0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata_m, e[31:0]);
                check("rsp_err", 32'(rsp_err_m), 32'(e[32]));
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!req_ready_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready_m;
        if (!ok) check("req_ready_timeout", 32'(req_ready_m), 32'h1);
    endtask

    task automatic issue(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic [31:0] exp_rdata, input bit exp_err);
        bit ok;
        int n;
        wait_ready(ok);
        if (!ok) return;
        #1;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
        exp_q.push_back({exp_err, exp_rdata});
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid_m && n < 40);
        check("accept_to_rsp_valid", 32'(n), 32'(lat_of[sel] + 1));
        @(negedge clk);
        check("req_ready_after_rsp", 32'(req_ready_m), 32'h1);
    endtask

    initial begin
        bit ok;
        int n;

        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready_m), 32'h1);
        check("reset_rsp_valid", 32'(rsp_valid_m), 32'h0);
        check("reset_rsp_rdata", rsp_rdata_m, 32'h0);
        check("reset_rsp_err", 32'(rsp_err_m), 32'h0);
        #1 rst = 1'b0;

        // Full write then read-back.
        issue(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 0);
        issue(0, 32'h8000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 0);

        // Partial writes onto a preset word, plus an all-zero mask.
        issue(1, 32'h8000_0014, 32'h1122_3344, 4'b1111, 32'h0, 0);
        issue(1, 32'h8000_0014, 32'h0000_AA00, 4'b0010, 32'h0, 0);
        issue(0, 32'h8000_0014, 32'h0,         4'b0000, 32'h1122_AA44, 0);
        issue(1, 32'h8000_0014, 32'hBBBB_0000, 4'b1100, 32'h0, 0);
        issue(0, 32'h8000_0014, 32'h0,         4'b0000, 32'hBBBB_AA44, 0);
        issue(1, 32'h8000_0014, 32'hFFFF_FFFF, 4'b0000, 32'h0, 0);
        issue(0, 32'h8000_0014, 32'h0,         4'b0000, 32'hBBBB_AA44, 0);

        // Range edges: words an index wrap would alias are preset and re-read.
        issue(1, 32'h8000_0000, 32'hCAFE_F00D, 4'b1111, 32'h0, 0);
        issue(1, 32'h8000_3FFC, 32'h0BAD_BEEF, 4'b1111, 32'h0, 0);
        issue(0, 32'h7FFF_FFFC, 32'h0,         4'b0000, 32'h0, 1);
        issue(1, 32'h8000_4000, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1);
        issue(0, 32'h8000_4000, 32'h0,         4'b0000, 32'h0, 1);
        issue(0, 32'h8000_0000, 32'h0,         4'b0000, 32'hCAFE_F00D, 0);
        issue(0, 32'h8000_3FFC, 32'h0,         4'b0000, 32'h0BAD_BEEF, 0);

        // Backpressure with req_valid held high throughout.
        @(posedge clk); #1 rsp_ready = 1'b0;
        wait_ready(ok);
        #1;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_wmask = 4'b0000;
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid_m && n < 40);
        check("bp_accept_to_rsp_valid", 32'(n), 32'h2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid_m), 32'h1);
            check("bp_rsp_rdata", rsp_rdata_m, 32'hDEAD_BEEF);
            check("bp_req_ready", 32'(req_ready_m), 32'h0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_req_ready_after_release", 32'(req_ready_m), 32'h1);
        #1 req_valid = 1'b0;

        // Latency extremes on the small instances.
        sel = 1;
        issue(1, 32'h8000_0008, 32'h55AA_55AA, 4'b1111, 32'h0, 0);
        issue(0, 32'h8000_0008, 32'h0,         4'b0000, 32'h55AA_55AA, 0);
        issue(0, 32'h8000_0040, 32'h0,         4'b0000, 32'h0, 1);
        sel = 2;
        issue(1, 32'h8000_003C, 32'h0102_0304, 4'b1111, 32'h0, 0);
        issue(0, 32'h8000_003C, 32'h0,         4'b0000, 32'h0102_0304, 0);
        sel = 0;

        // Reset while a write waits: the write must never land.
        issue(1, 32'h8000_0020, 32'h1234_5678, 4'b1111, 32'h0, 0);
        wait_ready(ok);
        #1;
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020;
        req_wdata = 32'hFFFF_FFFF; req_wmask = 4'b1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready_m), 32'h1);
        check("rst_rsp_valid", 32'(rsp_valid_m), 32'h0);
        check("rst_rsp_rdata", rsp_rdata_m, 32'h0);
        check("rst_rsp_err", 32'(rsp_err_m), 32'h0);
        @(negedge clk); #1 rst = 1'b0;
        issue(0, 32'h8000_0020, 32'h0, 4'b0000, 32'h1234_5678, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
